// File: rtl/mod_accumulator.sv
// Sequential modular accumulator: sums a stream of len operands mod q over valid/ready.
// Optional MOD_ACC_INPUT_REDUCE_EN applies one conditional subtraction to each operand (x < 2q).
module mod_accumulator #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] len,
    input  logic [DATA_WIDTH-1:0]  modulant,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   busy
);

    // Handshake: a beat moves on a rising edge where valid && ready are both high;
    // the source holds data stable while valid && !ready.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    state_t                 state;
    logic [DATA_WIDTH-1:0]  acc;
    logic [DATA_WIDTH-1:0]  q_lat;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [COUNT_WIDTH-1:0] len_lat;

    logic [DATA_WIDTH-1:0]  operand;
    logic [DATA_WIDTH:0]    sum;
    logic [DATA_WIDTH:0]    diff;
    logic [DATA_WIDTH-1:0]  acc_next;
    logic                   xfer;
    logic                   last_beat;

`ifdef MOD_ACC_INPUT_REDUCE_EN
    always_comb begin
        operand = in_data;
        if (in_data >= q_lat) begin
            operand = in_data - q_lat;
        end
    end
`else
    always_comb begin
        operand = in_data;
    end
`endif

    // Compare at DATA_WIDTH+1 bits so the carry out of acc + x takes part in the reduction.
    always_comb begin
        sum      = {1'b0, acc} + {1'b0, operand};
        diff     = sum - {1'b0, q_lat};
        acc_next = sum[DATA_WIDTH-1:0];
        if (sum >= {1'b0, q_lat}) begin
            acc_next = diff[DATA_WIDTH-1:0];
        end
    end

    assign in_ready  = (state == ACCUM);
    assign busy      = (state != IDLE);
    assign xfer      = in_valid && in_ready;
    assign last_beat = (cnt == (len_lat - CNT_ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            len_lat   <= '0;
            q_lat     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (start) begin
                        len_lat <= len;
                        q_lat   <= modulant;
                        acc     <= '0;
                        cnt     <= '0;
                        if (len == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= '0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc <= acc_next;
                        cnt <= cnt + CNT_ONE;
                        if (last_beat) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= acc_next;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
